// File: rtl/cpu_mem_responder_pkg.sv
// Shared types and helpers for the CPU memory responder.
// Optional MMIO output register is enabled with CPU_MEM_MMIO_EN (see top).
package cpu_mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Byte address of the memory-mapped output register.
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

  typedef struct packed {
    logic        ok;   // address falls inside the memory
    logic [29:0] idx;  // word index, already masked to the memory depth
  } word_addr_t;

  // Split a byte address into word index and in-range flag for a
  // power-of-two memory of 'depth' words. Byte offset bits are ignored.
  function automatic word_addr_t decode_addr(input logic [31:0] addr,
                                             input logic [31:0] depth);
    word_addr_t r;
    r.idx = addr[31:2] & (depth[29:0] - 30'd1);
    r.ok  = ({2'b00, addr[31:2]} < depth);
    return r;
  endfunction

endpackage

// File: rtl/cpu_mem_responder_byte_word_assembler.sv
// Collects a big-endian byte stream into 32-bit words for the loader.
// word/word_done are valid in the cycle the fourth byte is presented, so
// the caller can commit the word on that same edge.
module byte_word_assembler (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        clr,
  input  logic        Ld_valid,
  input  logic [7:0]  Ld_byte,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] shift_q;
  logic [1:0]  bcnt_q;

  // Shift bytes in MSB-first; clr abandons any partially assembled word
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      shift_q <= '0;
      bcnt_q  <= 2'd0;
    end else if (clr) begin
      bcnt_q  <= 2'd0;
    end else if (Ld_valid) begin
      shift_q <= {shift_q[15:0], Ld_byte};
      bcnt_q  <= bcnt_q + 2'd1;
    end
  end

  assign word      = {shift_q, Ld_byte};
  assign word_done = Ld_valid & (bcnt_q == 2'd3);

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the pipelined CPU: combinational IMEM/DMEM
// reads, clocked DMEM stores, and a byte-stream loader that fills IMEM
// while holding the CPU in reset.
// Define CPU_MEM_MMIO_EN to add the Io_out register at MMIO_ADDR.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 32
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] Iaddr,
  output logic [31:0] Inst,
  input  logic [31:0] Daddr,
  input  logic [31:0] Dwrite,
  input  logic        Wmem,
  output logic [31:0] Dread,
  input  logic        Ld_start,
  input  logic        Ld_valid,
  input  logic [7:0]  Ld_byte,
  input  logic        Ld_end,
  output logic        Cpu_clrn,
  output logic        Ld_ovf,
  output logic        Ld_busy
`ifdef CPU_MEM_MMIO_EN
  ,
  output logic [31:0] Io_out
`endif
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] IDEPTH = 32'(IMEM_WORDS);
  localparam logic [31:0] DDEPTH = 32'(DMEM_WORDS);
  localparam logic [IAW:0] PTR_ONE = (IAW + 1)'(1);

  state_e       state_q;
  logic [IAW:0] ptr_q;     // one extra bit so it can sit at IMEM_WORDS
  logic         cpu_clrn_q;
  logic         ovf_q;
  logic         busy_q;

  logic [31:0]  imem_q [IMEM_WORDS];
  logic [31:0]  dmem_q [DMEM_WORDS];

  word_addr_t   i_dec;
  word_addr_t   d_dec;
  logic         in_load;
  logic         asm_valid;
  logic         asm_clr;
  logic         asm_done;
  logic [31:0]  asm_word;
  logic         ptr_full;
  logic         imem_we;
  logic         mmio_hit;
  logic         dmem_we;
  logic         unused_addr_bits;

  assign i_dec   = decode_addr(Iaddr, IDEPTH);
  assign d_dec   = decode_addr(Daddr, DDEPTH);
  assign in_load = (state_q == LOAD);

  // Bytes only count while loading; a restart or end drops a partial word.
  assign asm_valid = Ld_valid & in_load;
  assign asm_clr   = Ld_start | (in_load & Ld_end);

  byte_word_assembler u_asm (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .clr       (asm_clr),
    .Ld_valid  (asm_valid),
    .Ld_byte   (Ld_byte),
    .word      (asm_word),
    .word_done (asm_done)
  );

  // ptr saturates at IMEM_WORDS, which is exactly when its top bit is set.
  assign ptr_full = ptr_q[IAW];
  // A restart takes priority over a word completing in the same cycle.
  assign imem_we  = asm_done & ~Ld_start & ~ptr_full;

`ifdef CPU_MEM_MMIO_EN
  assign mmio_hit = (Daddr == MMIO_ADDR);
`else
  assign mmio_hit = 1'b0;
`endif

  assign dmem_we = (state_q == RUN) & Wmem & d_dec.ok & ~mmio_hit;

  // Loader FSM: LOAD holds the CPU in reset, RUN releases it
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q    <= LOAD;
      ptr_q      <= '0;
      cpu_clrn_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b1;
    end else if (Ld_start) begin
      state_q    <= LOAD;
      ptr_q      <= '0;
      cpu_clrn_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b1;
    end else if (in_load) begin
      if (asm_done) begin
        if (ptr_full) ovf_q <= 1'b1;
        else          ptr_q <= ptr_q + PTR_ONE;
      end
      if (Ld_end) begin
        state_q    <= RUN;
        cpu_clrn_q <= 1'b1;
        busy_q     <= 1'b0;
      end
    end
  end

  // IMEM write port, driven only by the program loader
  always_ff @(posedge Clk) begin
    if (imem_we) imem_q[ptr_q[IAW-1:0]] <= asm_word;
  end

  // DMEM write port; reads see the old word until the next cycle
  always_ff @(posedge Clk) begin
    if (dmem_we) dmem_q[d_dec.idx[DAW-1:0]] <= Dwrite;
  end

  assign Inst = i_dec.ok ? imem_q[i_dec.idx[IAW-1:0]] : 32'd0;

`ifdef CPU_MEM_MMIO_EN
  logic [31:0] io_q;

  // Memory-mapped output register, written by stores in RUN
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn)                              io_q <= '0;
    else if ((state_q == RUN) && Wmem && mmio_hit) io_q <= Dwrite;
  end

  assign Io_out = io_q;
  assign Dread  = mmio_hit ? io_q : (d_dec.ok ? dmem_q[d_dec.idx[DAW-1:0]] : 32'd0);
`else
  assign Dread  = d_dec.ok ? dmem_q[d_dec.idx[DAW-1:0]] : 32'd0;
`endif

  assign Cpu_clrn = cpu_clrn_q;
  assign Ld_ovf   = ovf_q;
  assign Ld_busy  = busy_q;

  assign unused_addr_bits = ^{Iaddr[1:0], Daddr[1:0], i_dec.idx[29:IAW], d_dec.idx[29:DAW]};

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed loader/memory
// scenarios followed by randomized traffic, all compared every cycle
// against a queue/array model of the memory and loader behaviour.
module tb_cpu_mem_responder;

  localparam int IW = 4;
  localparam int DW = 32;
  localparam logic [31:0] IBYTES = 32'(IW * 4);
  localparam logic [31:0] DBYTES = 32'(DW * 4);
  localparam logic [31:0] MMIO_A = 32'hFFFF_FFF0;
`ifdef CPU_MEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        Clk;
  logic        Clrn;
  logic [31:0] Iaddr;
  logic [31:0] Inst;
  logic [31:0] Daddr;
  logic [31:0] Dwrite;
  logic        Wmem;
  logic [31:0] Dread;
  logic        Ld_start;
  logic        Ld_valid;
  logic [7:0]  Ld_byte;
  logic        Ld_end;
  logic        Cpu_clrn;
  logic        Ld_ovf;
  logic        Ld_busy;
`ifdef CPU_MEM_MMIO_EN
  logic [31:0] Io_out;
`endif

  cpu_mem_responder #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
    .Clk      (Clk),
    .Clrn     (Clrn),
    .Iaddr    (Iaddr),
    .Inst     (Inst),
    .Daddr    (Daddr),
    .Dwrite   (Dwrite),
    .Wmem     (Wmem),
    .Dread    (Dread),
    .Ld_start (Ld_start),
    .Ld_valid (Ld_valid),
    .Ld_byte  (Ld_byte),
    .Ld_end   (Ld_end),
    .Cpu_clrn (Cpu_clrn),
    .Ld_ovf   (Ld_ovf),
    .Ld_busy  (Ld_busy)
`ifdef CPU_MEM_MMIO_EN
    ,
    .Io_out   (Io_out)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  logic [31:0]  m_imem [IW];
  bit           m_ik   [IW];
  logic [31:0]  m_dmem [DW];
  bit           m_dk   [DW];
  bit           m_run;
  bit           m_ovf;
  int           m_ptr;
  byte unsigned m_bytes [$];
  logic [31:0]  m_io;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_ovf = 1'b0;
    m_ptr = 0;
    m_bytes.delete();
    m_io  = 32'd0;
  endtask

  // Advance the model by one rising edge using the inputs held this cycle.
  task automatic model_step();
    logic [31:0] w;
    if (!Clrn) begin
      model_reset();
      return;
    end
    if (m_run && Wmem) begin
      if (MMIO && Daddr == MMIO_A) m_io = Dwrite;
      else if (Daddr < DBYTES) begin
        m_dmem[int'(Daddr >> 2)] = Dwrite;
        m_dk[int'(Daddr >> 2)]   = 1'b1;
      end
    end
    if (Ld_start) begin
      m_run = 1'b0;
      m_ovf = 1'b0;
      m_ptr = 0;
      m_bytes.delete();
    end else if (!m_run) begin
      if (Ld_valid) begin
        m_bytes.push_back(Ld_byte);
        if (m_bytes.size() == 4) begin
          w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          if (m_ptr < IW) begin
            m_imem[m_ptr] = w;
            m_ik[m_ptr]   = 1'b1;
            m_ptr++;
          end else begin
            m_ovf = 1'b1;
          end
          m_bytes.delete();
        end
      end
      if (Ld_end) begin
        m_run = 1'b1;
        m_bytes.delete();
      end
    end
  endtask

  // Compare every output against the model, half a cycle from the edge
  always @(negedge Clk) begin
    check("Cpu_clrn", 32'(Cpu_clrn), 32'(m_run));
    check("Ld_busy", 32'(Ld_busy), 32'(!m_run));
    check("Ld_ovf", 32'(Ld_ovf), 32'(m_ovf));
    if (Iaddr >= IBYTES) check("Inst_oor", Inst, 32'd0);
    else if (m_ik[int'(Iaddr >> 2)]) check("Inst", Inst, m_imem[int'(Iaddr >> 2)]);
    if (MMIO && Daddr == MMIO_A) check("Dread_mmio", Dread, m_io);
    else if (Daddr >= DBYTES) check("Dread_oor", Dread, 32'd0);
    else if (m_dk[int'(Daddr >> 2)]) check("Dread", Dread, m_dmem[int'(Daddr >> 2)]);
`ifdef CPU_MEM_MMIO_EN
    check("Io_out", Io_out, m_io);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    Ld_valid = 1'b1;
    Ld_byte  = b;
    tick();
    Ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    Ld_start = 1'b1;
    tick();
    Ld_start = 1'b0;
  endtask

  task automatic pulse_end();
    Ld_end = 1'b1;
    tick();
    Ld_end = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Wmem   = 1'b1;
    Daddr  = a;
    Dwrite = d;
    tick();
    Wmem   = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Clrn = 1'b0; Iaddr = '0; Daddr = '0; Dwrite = '0; Wmem = 1'b0;
    Ld_start = 1'b0; Ld_valid = 1'b0; Ld_byte = '0; Ld_end = 1'b0;
    for (int i = 0; i < IW; i++) begin m_imem[i] = '0; m_ik[i] = 1'b0; end
    for (int i = 0; i < DW; i++) begin m_dmem[i] = '0; m_dk[i] = 1'b0; end
    model_reset();

    // Reset state
    tick();
    #1;
    check("rst_cpu_clrn", 32'(Cpu_clrn), 32'd0);
    check("rst_busy", 32'(Ld_busy), 32'd1);
    check("rst_ovf", 32'(Ld_ovf), 32'd0);
    tick();
    Clrn = 1'b1;

    // Two-word program load
    pulse_start();
    send_word(32'h2001_0005);
    send_word(32'h8C02_0000);
    Ld_end = 1'b1;
    #1;
    check("clrn_before_end", 32'(Cpu_clrn), 32'd0);
    tick();
    Ld_end = 1'b0;
    check("clrn_after_end", 32'(Cpu_clrn), 32'd1);
    Iaddr = 32'd0;
    #1;
    check("imem0", Inst, 32'h2001_0005);
    Iaddr = 32'd4;
    #1;
    check("imem1", Inst, 32'h8C02_0000);

    // Give DMEM known contents
    for (int i = 0; i < DW; i++) store(32'(i * 4), 32'd0);

    // Store then read-back timing, byte offset ignored
    Wmem = 1'b1; Daddr = 32'h0C; Dwrite = 32'hDEAD_BEEF;
    #1;
    check("read_during_write", Dread, 32'd0);
    tick();
    Wmem = 1'b0;
    #1;
    check("read_after_write", Dread, 32'hDEAD_BEEF);
    Daddr = 32'h0F;
    #1;
    check("byte_offset_alias", Dread, 32'hDEAD_BEEF);

    // Out-of-range store is dropped
    Wmem = 1'b1; Daddr = 32'h1000_0000; Dwrite = 32'h1234_5678;
    #1;
    check("oor_read", Dread, 32'd0);
    tick();
    Wmem = 1'b0;
    Daddr = 32'h0;
    #1;
    check("oor_no_alias", Dread, 32'd0);

    // Overflow: five words into a four-word IMEM
    pulse_start();
    for (int k = 0; k < 5; k++) send_word(32'hC0DE_0000 | 32'(k));
    #1;
    check("ovf_set", 32'(Ld_ovf), 32'd1);
    Iaddr = 32'd12;
    #1;
    check("imem3_after_ovf", Inst, 32'hC0DE_0003);

    // Restart clears ovf; a trailing partial word is discarded
    pulse_start();
    check("ovf_cleared", 32'(Ld_ovf), 32'd0);
    send_word(32'hA1B2_C3D4);
    send_byte(8'hE5);
    send_byte(8'hF6);
    pulse_end();
    Iaddr = 32'd0;
    #1;
    check("reload_imem0", Inst, 32'hA1B2_C3D4);
    Iaddr = 32'd4;
    #1;
    check("partial_dropped", Inst, 32'hC0DE_0001);

    // Start and end together in RUN: start wins
    Ld_start = 1'b1; Ld_end = 1'b1;
    tick();
    Ld_start = 1'b0; Ld_end = 1'b0;
    check("start_wins_clrn", 32'(Cpu_clrn), 32'd0);
    check("start_wins_busy", 32'(Ld_busy), 32'd1);

    // Asynchronous reset in the middle of a word
    send_word(32'h0BAD_F00D);
    send_byte(8'h01);
    send_byte(8'h02);
    Iaddr = 32'd0;
    Clrn = 1'b0;
    model_reset();
    #1;
    check("midload_rst_busy", 32'(Ld_busy), 32'd1);
    check("midload_rst_clrn", 32'(Cpu_clrn), 32'd0);
    check("midload_rst_kept", Inst, 32'h0BAD_F00D);
    tick();
    Clrn = 1'b1;

    // MMIO register (or its absence)
    pulse_end();
    store(MMIO_A, 32'h0000_00A5);
    #1;
`ifdef CPU_MEM_MMIO_EN
    check("io_out", Io_out, 32'h0000_00A5);
    check("mmio_load", Dread, 32'h0000_00A5);
`else
    check("mmio_absent_load", Dread, 32'd0);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) < 3) begin
        Ld_start = 1'b0; Ld_end = 1'b0; Ld_valid = 1'b0; Wmem = 1'b0;
        Clrn = 1'b0;
        model_reset();
        tick();
        Clrn = 1'b1;
        continue;
      end
      Ld_start = m_run ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 1);
      Ld_end   = m_run ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 3);
      Ld_valid = ($urandom_range(0, 99) < 60);
      Ld_byte  = 8'($urandom);
      Wmem     = ($urandom_range(0, 99) < 40);
      Dwrite   = $urandom;
      case ($urandom_range(0, 9))
        0:       Daddr = MMIO_A;
        1:       Daddr = $urandom;
        default: Daddr = 32'($urandom_range(0, int'(DBYTES) - 1));
      endcase
      Iaddr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, int'(IBYTES) - 1));
      tick();
    end
    Ld_start = 1'b0; Ld_end = 1'b0; Ld_valid = 1'b0; Wmem = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
